// File: rtl/pp_pkg.sv
// rtl/pp_pkg.sv - shared defaults, FSM states and LFSR constants for pp_stream_chk
package pp_pkg;

  localparam int DATA_W_DEF = 64;
  localparam int ADDR_W_DEF = 6;
  localparam int CNT_W_DEF  = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // x^16 + x^14 + x^13 + x^11 + 1 -> taps on state bits 15, 13, 12, 10
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic lfsr16_fb(input logic [15:0] s);
    return ^(s & LFSR_TAPS);
  endfunction

  function automatic logic [15:0] lfsr16_next(input logic [15:0] s);
    return {s[14:0], lfsr16_fb(s)};
  endfunction

endpackage

// File: rtl/pp_lfsr16.sv
// rtl/pp_lfsr16.sv - free-running 16-bit Fibonacci LFSR used for ready throttling
module pp_lfsr16
  import pp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] state
);

  // advance one step every cycle; reset parks it on the seed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= LFSR_SEED;
    else     state <= lfsr16_next(state);
  end

endmodule

// File: rtl/pp_stream_chk.sv
// rtl/pp_stream_chk.sv - incrementing-pattern checker for ping-pong buffer output (option: PP_STREAM_CHK_THROTTLE_EN)
module pp_stream_chk
  import pp_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              i_start,
  input  logic              i_stop,
  input  logic [DATA_W-1:0] i_seed,
  input  logic              i_throttle_en,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_ready,
  output logic              o_busy,
  output logic              o_frame_done,
  output logic [CNT_W-1:0]  o_frame_cnt,
  output logic [CNT_W-1:0]  o_err_cnt,
  output logic              o_err,
  output logic [ADDR_W-1:0] o_err_addr,
  output logic [DATA_W-1:0] o_err_data
);

  localparam logic [ADDR_W-1:0] LAST_IDX = '1;
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  state_t            state;
  logic              ready;
  logic              accept;
  logic              last_beat;
  logic              mismatch;
  logic              throttle_next;
  logic [DATA_W-1:0] expected;
  logic [ADDR_W-1:0] beat_idx;

  assign accept    = i_valid & ready;
  assign last_beat = (beat_idx == LAST_IDX);
  assign mismatch  = (i_data != expected);
  assign o_ready   = ready;
  assign o_busy    = (state != IDLE);

`ifdef PP_STREAM_CHK_THROTTLE_EN
  logic [15:0] lfsr;

  pp_lfsr16 u_lfsr (
    .clk   (sys_clk),
    .rst   (sys_rst),
    .state (lfsr)
  );

  // the feedback bit becomes LFSR bit 0 next cycle, so ready registered from it
  // is low exactly in the cycles where the LFSR register holds bit 0 = 1
  assign throttle_next = i_throttle_en & lfsr16_fb(lfsr);
`else
  logic unused_throttle;
  assign unused_throttle = i_throttle_en;
  assign throttle_next   = 1'b0;
`endif

  // control FSM, beat comparison, first-error capture and saturating counters
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state        <= IDLE;
      ready        <= 1'b0;
      o_frame_done <= 1'b0;
      o_frame_cnt  <= '0;
      o_err_cnt    <= '0;
      o_err        <= 1'b0;
      o_err_addr   <= '0;
      o_err_data   <= '0;
      expected     <= '0;
      beat_idx     <= '0;
    end else begin
      o_frame_done <= 1'b0;

      if (accept) begin
        expected <= expected + DATA_W'(1);
        beat_idx <= beat_idx + ADDR_W'(1);
        if (mismatch) begin
          o_err <= 1'b1;
          if (o_err_cnt != CNT_MAX) o_err_cnt <= o_err_cnt + CNT_W'(1);
          if (!o_err) begin
            o_err_addr <= beat_idx;
            o_err_data <= i_data;
          end
        end
        if (last_beat) begin
          o_frame_done <= 1'b1;
          if (o_frame_cnt != CNT_MAX) o_frame_cnt <= o_frame_cnt + CNT_W'(1);
        end
      end

      case (state)
        IDLE: begin
          ready <= 1'b0;
          if (i_start) begin
            state       <= RUN;
            ready       <= ~throttle_next;
            expected    <= i_seed;
            beat_idx    <= '0;
            o_frame_cnt <= '0;
            o_err_cnt   <= '0;
            o_err       <= 1'b0;
            o_err_addr  <= '0;
            o_err_data  <= '0;
          end
        end
        RUN: begin
          ready <= ~throttle_next;
          if (i_stop) begin
            if (accept && last_beat) begin
              state <= IDLE;
              ready <= 1'b0;
            end else begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          ready <= ~throttle_next;
          if (accept && last_beat) begin
            state <= IDLE;
            ready <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pp_stream_chk.sv
// tb/tb_pp_stream_chk.sv - directed and randomized self-checking bench for pp_stream_chk
module tb_pp_stream_chk;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        i_start = 1'b0;
  logic        i_stop = 1'b0;
  logic [63:0] i_seed = '0;
  logic        i_throttle_en = 1'b0;
  logic        i_valid = 1'b0;
  logic [63:0] i_data = '0;
  logic        o_ready, o_busy, o_frame_done, o_err;
  logic [15:0] o_frame_cnt, o_err_cnt;
  logic [5:0]  o_err_addr;
  logic [63:0] o_err_data;

  pp_stream_chk #(.DATA_W(64), .ADDR_W(6), .CNT_W(16)) dut (
    .sys_clk       (sys_clk),
    .sys_rst       (sys_rst),
    .i_start       (i_start),
    .i_stop        (i_stop),
    .i_seed        (i_seed),
    .i_throttle_en (i_throttle_en),
    .i_valid       (i_valid),
    .i_data        (i_data),
    .o_ready       (o_ready),
    .o_busy        (o_busy),
    .o_frame_done  (o_frame_done),
    .o_frame_cnt   (o_frame_cnt),
    .o_err_cnt     (o_err_cnt),
    .o_err         (o_err),
    .o_err_addr    (o_err_addr),
    .o_err_data    (o_err_data)
  );

  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int errors = 0;

  // reference model: session flag, pending-stop flag, beat position, counters
  bit          m_on, m_drain, m_err, m_done, m_acc;
  int          m_beat, m_frames, m_errs;
  logic [63:0] m_exp, m_err_data;
  logic [5:0]  m_err_addr;
  logic [15:0] m_lfsr;
  logic [63:0] bad [int];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit thr_on();
`ifdef PP_STREAM_CHK_THROTTLE_EN
    return i_throttle_en && m_lfsr[0];
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit m_ready();
    return m_on && !thr_on();
  endfunction

  task automatic model_reset();
    m_on = 0; m_drain = 0; m_err = 0; m_done = 0; m_acc = 0;
    m_beat = 0; m_frames = 0; m_errs = 0;
    m_exp = '0; m_err_data = '0; m_err_addr = '0;
    m_lfsr = 16'hACE1;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".ready"},      o_ready,      m_ready());
    chk({tag, ".busy"},       o_busy,       m_on);
    chk({tag, ".frame_done"}, o_frame_done, m_done);
    chk({tag, ".frame_cnt"},  o_frame_cnt,  m_frames[15:0]);
    chk({tag, ".err_cnt"},    o_err_cnt,    m_errs[15:0]);
    chk({tag, ".err"},        o_err,        m_err);
    chk({tag, ".err_addr"},   o_err_addr,   m_err_addr);
    chk({tag, ".err_data"},   o_err_data,   m_err_data);
  endtask

  // advance model by one cycle from the current inputs, then compare after the edge
  task automatic tick(input string tag);
    bit rdy, last, mis;
    rdy   = m_ready();
    m_acc = i_valid && rdy;
    m_done = 0;
    if (!m_on) begin
      if (i_start) begin
        m_on = 1; m_drain = 0; m_exp = i_seed; m_beat = 0;
        m_frames = 0; m_errs = 0; m_err = 0; m_err_addr = '0; m_err_data = '0;
      end
    end else begin
      last = (m_beat == 63);
      if (m_acc) begin
        mis = (i_data !== m_exp);
        if (mis) begin
          if (!m_err) begin
            m_err_addr = m_beat[5:0];
            m_err_data = i_data;
          end
          m_err = 1;
          if (m_errs < 65535) m_errs++;
        end
        m_exp  = m_exp + 64'd1;
        m_beat = (m_beat + 1) % 64;
        if (last) begin
          m_done = 1;
          if (m_frames < 65535) m_frames++;
        end
      end
      if (m_acc && last && (i_stop || m_drain)) begin
        m_on = 0; m_drain = 0;
      end else if (i_stop) begin
        m_drain = 1;
      end
    end
    @(posedge sys_clk);
    m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    sys_rst = 1; i_start = 0; i_stop = 0; i_valid = 0;
    model_reset();
    #1;
    check_all("rst_async");
    repeat (2) @(posedge sys_clk);
    #1;
    check_all("rst_hold");
    sys_rst = 0;
    repeat (3) tick("idle_after_rst");
  endtask

  task automatic start(input logic [63:0] seed, input bit with_stop);
    i_start = 1; i_stop = with_stop; i_seed = seed; i_valid = 1; i_data = {$urandom, $urandom};
    tick("start");
    i_start = 0; i_stop = 0; i_valid = 0;
  endtask

  // presents beats base+k (or bad[k]) until n beats are taken; stop/start pulsed once at a beat index
  task automatic stream(input string tag, input int n, input logic [63:0] base, input bit rnd,
                        input int stop_at, input int start_at);
    int k = 0;
    int cyc = 0;
    bit stop_sent = 0;
    bit start_sent = 0;
    while (k < n && cyc < 1000) begin
      i_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      i_data  = i_valid ? (bad.exists(k) ? bad[k] : base + 64'(k)) : {$urandom, $urandom};
      i_stop  = (k == stop_at) && !stop_sent;
      i_start = (k == start_at) && !start_sent;
      i_seed  = {$urandom, $urandom};
      stop_sent  = stop_sent | i_stop;
      start_sent = start_sent | i_start;
      tick(tag);
      if (m_acc) k++;
      cyc++;
    end
    i_valid = 0; i_stop = 0; i_start = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] s;
    model_reset();
    do_reset();
    chk("reset_ready", o_ready, 0);
    chk("reset_frame_cnt", o_frame_cnt, 0);

    // clean frame, stop coincides with the last beat -> straight to IDLE
    start(64'h100, 0);
    stream("clean", 64, 64'h100, 0, 63, -1);
    chk("clean_frame_cnt", o_frame_cnt, 1);
    chk("clean_frame_done", o_frame_done, 1);
    chk("clean_err", o_err, 0);
    chk("clean_idle", o_busy, 0);
    tick("clean_after");
    chk("clean_done_once", o_frame_done, 0);

    // two corrupted beats, only the first one is captured
    bad.delete();
    bad[5] = 64'hDEAD;
    bad[9] = 64'h109 ^ 64'h80;
    start(64'h100, 0);
    stream("corrupt", 64, 64'h100, 0, 63, -1);
    bad.delete();
    chk("corrupt_err", o_err, 1);
    chk("corrupt_err_cnt", o_err_cnt, 2);
    chk("corrupt_err_addr", o_err_addr, 5);
    chk("corrupt_err_data", o_err_data, 64'hDEAD);

    // stop at beat 10 of frame 2: rest of the frame drains, then IDLE
    s = {$urandom, $urandom};
    start(s, 0);
    stream("drain", 128, s, 0, 74, -1);
    chk("drain_frame_cnt", o_frame_cnt, 2);
    chk("drain_busy", o_busy, 0);
    chk("drain_ready", o_ready, 0);
    i_valid = 1; i_data = s + 64'd128;
    repeat (3) tick("drain_idle");
    i_valid = 0;
    chk("drain_no_accept", o_frame_cnt, 2);

    // random valid gaps, random corruption, stray start while running
    s = {$urandom, $urandom};
    bad[$urandom_range(0, 127)] = {$urandom, $urandom} ^ 64'h1;
    start(s, 0);
    stream("random", 128, s, 1, 120, 30);
    bad.delete();
    chk("random_idle", o_busy, 0);

    // expected value wraps through zero
    start(64'hFFFF_FFFF_FFFF_FFFE, 0);
    stream("wrap", 4, 64'hFFFF_FFFF_FFFF_FFFE, 0, -1, -1);
    chk("wrap_err", o_err, 0);
    chk("wrap_err_cnt", o_err_cnt, 0);

    // async reset at beat 30 abandons the frame
    stream("pre_rst", 26, 64'h2, 0, -1, -1);
    i_valid = 1; i_data = 64'h1C;
    #3;
    do_reset();
    chk("midrst_busy", o_busy, 0);
    chk("midrst_frame_done", o_frame_done, 0);
    chk("midrst_frame_cnt", o_frame_cnt, 0);

    // throttled frame; start and stop together in IDLE means start
    i_throttle_en = 1;
    s = {$urandom, $urandom};
    start(s, 1);
    stream("throttle", 64, s, 0, 63, -1);
    chk("throttle_frame_cnt", o_frame_cnt, 1);
    chk("throttle_err", o_err, 0);
    i_throttle_en = 0;
    tick("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
